// File: rtl/datain_sink.sv
// Flit sink: classifies incoming flits, buffers non-null ones in a FIFO, keeps
// saturating statistics and detects end-of-stream after an idle timeout.
module datain_sink #(
   parameter logic [3:0] NODE_ID    = 4'd0,
   parameter int         FIFO_DEPTH = 16,
   parameter int         TIMEOUT    = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [19:0] datain,
   input  logic        clear,
   input  logic        rd_en,
   output logic [19:0] rd_data,
   output logic        rd_valid,
   output logic        fifo_empty,
   output logic        fifo_full,
   output logic        overflow,
   output logic [7:0]  rx_count,
   output logic [7:0]  err_count,
   output logic [7:0]  null_count,
   output logic        err_pulse,
   output logic [15:0] src_seen,
   output logic        all_seen,
   output logic        done
);

   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [7:0]  LAST_IDLE = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t        state, state_nxt;
   logic [19:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [7:0]    idle_cnt;
   logic          flit_null, flit_data, flit_err, do_wr, do_rd;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == DEPTH_C);
   assign all_seen   = ((src_seen | (16'd1 << NODE_ID)) == 16'hFFFF);

   // A flit is good only when addressed to us, payload echoes dest, and it
   // did not come from ourselves.
   always_comb begin
      flit_null = in_valid && (datain == 20'h00000);
      flit_data = in_valid && (datain != 20'h00000);
      flit_err  = flit_data && ((datain[7:4] != NODE_ID) ||
                                (datain[3:0] != datain[7:4]) ||
                                (datain[15:12] == NODE_ID));
      do_rd     = rd_en && !fifo_empty && !clear;
      do_wr     = flit_data && (!fifo_full || rd_en) && !clear;
   end

   // NOTE: the storage array has no reset; only pointers and count define
   // what is valid, so the RAM can map onto plain memory cells.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= datain;
   end

   // NOTE: every register here uses non-blocking assignment so all updates
   // see the pre-edge values, matching real flop behaviour.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         rd_data    <= 20'h00000;
         rd_valid   <= 1'b0;
         overflow   <= 1'b0;
         rx_count   <= 8'h00;
         err_count  <= 8'h00;
         null_count <= 8'h00;
         err_pulse  <= 1'b0;
         src_seen   <= 16'h0000;
         idle_cnt   <= 8'h00;
      end else if (clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         rd_data    <= 20'h00000;
         rd_valid   <= 1'b0;
         overflow   <= 1'b0;
         rx_count   <= 8'h00;
         err_count  <= 8'h00;
         null_count <= 8'h00;
         err_pulse  <= 1'b0;
         src_seen   <= 16'h0000;
         idle_cnt   <= 8'h00;
      end else begin
         if (flit_null) null_count <= sat_inc(null_count);
         if (flit_data) begin
            rx_count <= sat_inc(rx_count);
            src_seen <= src_seen | (16'd1 << datain[15:12]);
         end
         if (flit_err) err_count <= sat_inc(err_count);
         err_pulse <= flit_err;
         if (flit_data && fifo_full && !rd_en) overflow <= 1'b1;

         if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_rd) begin
            rd_ptr  <= rd_ptr + PTR_ONE;
            rd_data <= mem[rd_ptr];
         end
         rd_valid <= do_rd;

         case ({do_wr, do_rd})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase

         if (state == ACTIVE)
            idle_cnt <= in_valid ? 8'h00 : idle_cnt + 8'd1;
         else
            idle_cnt <= 8'h00;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // NOTE: state_nxt defaults to the current state before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (flit_data) state_nxt = ACTIVE;
         ACTIVE:  if (!in_valid && idle_cnt == LAST_IDLE) state_nxt = DONE;
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
      if (clear) state_nxt = IDLE;
   end

   always_comb begin
      done = (state == DONE);
   end

endmodule

// File: tb/tb_datain_sink.sv
// Scoreboard bench for datain_sink: queue-based reference model, directed
// scenarios plus a randomized phase, pops checked by a separate monitor.
module tb_datain_sink;

   localparam logic [3:0] NODE  = 4'd1;
   localparam int         DEPTH = 16;
   localparam int         TMO   = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [19:0] datain = 20'h0;
   logic        clear = 1'b0;
   logic        rd_en = 1'b0;
   logic [19:0] rd_data;
   logic        rd_valid, fifo_empty, fifo_full, overflow, err_pulse;
   logic [7:0]  rx_count, err_count, null_count;
   logic [15:0] src_seen;
   logic        all_seen, done;

   always #5 clk = ~clk;

   datain_sink #(.NODE_ID(NODE), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .datain(datain),
      .clear(clear), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
      .fifo_empty(fifo_empty), .fifo_full(fifo_full), .overflow(overflow),
      .rx_count(rx_count), .err_count(err_count), .null_count(null_count),
      .err_pulse(err_pulse), .src_seen(src_seen), .all_seen(all_seen),
      .done(done)
   );

   int checks = 0;
   int failures = 0;

   // reference model state
   logic [19:0] m_fifo[$];
   logic [19:0] exp_q[$];
   int          m_rx, m_err, m_null, cyc, last_v;
   logic [15:0] m_seen;
   logic [19:0] m_rd_data;
   bit          m_ovf, m_err_pulse, m_started, m_done;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v);
      return (v < 255) ? v + 1 : 255;
   endfunction

   task automatic model_reset();
      m_fifo.delete();
      m_rx = 0; m_err = 0; m_null = 0; m_seen = 16'h0;
      m_rd_data = 20'h0; m_ovf = 0; m_err_pulse = 0;
      m_started = 0; m_done = 0;
   endtask

   task automatic model_step(input logic v, input logic [19:0] d, input logic rd, input logic clr);
      bit good;
      cyc++;
      if (clr) begin
         model_reset();
         return;
      end
      m_err_pulse = 0;
      if (rd && m_fifo.size() > 0) begin
         m_rd_data = m_fifo.pop_front();
         exp_q.push_back(m_rd_data);
      end
      if (v) begin
         last_v = cyc;
         if (d == 20'h0) m_null = sat(m_null);
         else begin
            m_rx = sat(m_rx);
            m_seen[d[15:12]] = 1'b1;
            if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
            else m_ovf = 1;
            good = (d[7:4] == NODE) && (d[3:0] == NODE) && (d[15:12] != NODE);
            if (!good) begin
               m_err = sat(m_err);
               m_err_pulse = 1;
            end
            m_started = 1;
         end
      end
      if (m_started && (cyc - last_v >= TMO)) m_done = 1;
   endtask

   task automatic check_all();
      check("rx_count",   32'(rx_count),   32'(m_rx));
      check("err_count",  32'(err_count),  32'(m_err));
      check("null_count", 32'(null_count), 32'(m_null));
      check("src_seen",   32'(src_seen),   32'(m_seen));
      check("all_seen",   32'(all_seen),   32'((m_seen | (16'd1 << NODE)) == 16'hFFFF));
      check("overflow",   32'(overflow),   32'(m_ovf));
      check("fifo_empty", 32'(fifo_empty), 32'(m_fifo.size() == 0));
      check("fifo_full",  32'(fifo_full),  32'(m_fifo.size() == DEPTH));
      check("done",       32'(done),       32'(m_done));
      check("err_pulse",  32'(err_pulse),  32'(m_err_pulse));
      check("rd_data",    32'(rd_data),    32'(m_rd_data));
   endtask

   task automatic step(input logic v, input logic [19:0] d, input logic rd, input logic clr);
      in_valid = v; datain = d; rd_en = rd; clear = clr;
      @(posedge clk);
      model_step(v, d, rd, clr);
      #1;
      check_all();
   endtask

   function automatic logic [19:0] good_flit(input logic [3:0] src, input logic [3:0] tag);
      return {tag, src, ~tag, NODE, NODE};
   endfunction

   function automatic logic [19:0] rand_flit();
      int r = $urandom_range(0, 9);
      logic [3:0] s;
      if (r < 2) return 20'h0;
      if (r < 7) begin
         s = 4'($urandom_range(0, 15));
         if (s == NODE) s = s + 4'd1;
         return good_flit(s, 4'($urandom));
      end
      return 20'($urandom);
   endfunction

   // monitor: every rd_valid pulse must match the oldest expected pop
   initial begin
      logic [19:0] e;
      forever begin
         @(negedge clk);
         if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rd_valid_unexpected: got rd_valid=1 data=%0h expected no pop (t=%0t)", rd_data, $time);
            end else begin
               e = exp_q.pop_front();
               check("pop_data", 32'(rd_data), 32'(e));
            end
         end
      end
   end

   initial begin
      cyc = 0; last_v = 0;
      model_reset();
      #12;
      check_all();
      check("rd_valid_reset", 32'(rd_valid), 32'(0));
      #10 rst = 1'b1;

      // two good flits, then popped in order
      step(1, 20'h0F011, 0, 0);
      step(1, 20'h0E011, 0, 0);
      check("rx_two",   32'(rx_count),  32'(2));
      check("err_zero", 32'(err_count), 32'(0));
      check("seen_c000", 32'(src_seen), 32'(16'hC000));
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      check("rd_first_last", 32'(rd_data), 32'(20'h0E011));

      // erroneous flit: pulse next cycle, still stored
      step(0, 0, 0, 1);
      step(1, 20'h02022, 0, 0);
      check("err_pulse_hi", 32'(err_pulse), 32'(1));
      check("err_count_1",  32'(err_count), 32'(1));
      step(0, 0, 1, 0);
      check("err_pulse_lo", 32'(err_pulse), 32'(0));
      check("err_stored",   32'(rd_data),   32'(20'h02022));

      // overflow on 17th write; then drain including reads past empty
      step(0, 0, 0, 1);
      for (int i = 0; i < 17; i++) step(1, good_flit(4'hF, 4'(i + 1)), 0, 0);
      check("full_17",  32'(fifo_full), 32'(1));
      check("ovf_17",   32'(overflow),  32'(1));
      check("rx_17",    32'(rx_count),  32'(17));
      for (int i = 0; i < 18; i++) step(0, 0, 1, 0);
      // write to empty FIFO with rd_en: stored, not bypassed
      step(1, 20'h0A011, 1, 0);
      check("empty_wr_stored", 32'(fifo_empty), 32'(0));
      // full with simultaneous read and write: no overflow
      step(0, 0, 0, 1);
      for (int i = 0; i < 16; i++) step(1, good_flit(4'h3, 4'(i)), 0, 0);
      step(1, 20'h05011, 1, 0);
      check("full_rw_no_ovf", 32'(overflow),  32'(0));
      check("full_rw_full",   32'(fifo_full), 32'(1));

      // nulls, one good flit, then timeout
      step(0, 0, 0, 1);
      for (int i = 0; i < 15; i++) step(1, 20'h0, 0, 0);
      step(1, 20'h07011, 0, 0);
      check("null_15", 32'(null_count), 32'(15));
      for (int k = 1; k <= 70; k++) begin
         step(0, 0, 0, 0);
         if (k == 63) check("done_at_63", 32'(done), 32'(0));
         if (k == 64) check("done_at_64", 32'(done), 32'(1));
      end
      step(1, 20'h08011, 0, 0);
      check("done_sticky", 32'(done), 32'(1));
      check("rx_in_done",  32'(rx_count), 32'(2));

      // all sources seen, then clear back to reset values
      step(0, 0, 0, 1);
      for (int s = 0; s < 16; s++) begin
         if (s == 15) check("all_seen_pre", 32'(all_seen), 32'(0));
         if (s != NODE) step(1, good_flit(4'(s), 4'(s)), 0, 0);
      end
      check("all_seen", 32'(all_seen), 32'(1));
      step(0, 0, 1, 1);
      check("clr_seen", 32'(src_seen), 32'(0));
      check("clr_rx",   32'(rx_count), 32'(0));
      check("clr_done", 32'(done),     32'(0));
      check("clr_rdv",  32'(rd_valid), 32'(0));

      // saturation
      for (int i = 0; i < 260; i++) step(1, 20'h02022, 1, 0);
      check("rx_sat",  32'(rx_count),  32'(255));
      check("err_sat", 32'(err_count), 32'(255));
      for (int i = 0; i < 260; i++) step(1, 20'h0, 0, 0);
      check("null_sat", 32'(null_count), 32'(255));

      // randomized traffic
      step(0, 0, 0, 1);
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, rand_flit(), $urandom_range(0, 9) < 4,
              $urandom_range(0, 99) < 2);

      // asynchronous reset mid-stream with FIFO half full
      step(0, 0, 0, 1);
      for (int i = 0; i < 8; i++) step(1, good_flit(4'h9, 4'(i)), 0, 0);
      step(0, 0, 1, 0);
      #2 rst = 1'b0;
      #1;
      model_reset();
      exp_q.delete();
      check_all();
      check("rst_empty", 32'(fifo_empty), 32'(1));
      check("rst_rx",    32'(rx_count),   32'(0));
      check("rst_rdv",   32'(rd_valid),   32'(0));
      check("rst_rdd",   32'(rd_data),    32'(0));
      #2 rst = 1'b1;
      step(1, 20'h0C011, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);

      check("pending_pops", 32'(exp_q.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/datain_sink.md
DATAIN_SINK -- requirements
Module: datain_sink

Interface
REQ-001 SHALL have parameter NODE_ID, 4'd0, node address of this sink (0-15).
REQ-002 SHALL have parameter FIFO_DEPTH, 16, capture FIFO entries (power of 2).
REQ-003 SHALL have parameter TIMEOUT, 64, idle cycles after last flit before done (1-255).
REQ-004 SHALL have port: clk  input  1  clock, rising edge.
REQ-005 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: in_valid  input  1  flit present on datain this cycle.
REQ-007 SHALL have port: datain  input  20  flit; [15:12] src, [7:4] dest, [3:0] payload, [19:16] and [11:8] reserved.
REQ-008 SHALL have port: clear  input  1  synchronous clear of all state.
REQ-009 SHALL have port: rd_en  input  1  pop one FIFO entry.
REQ-010 SHALL have port: rd_data  output  20  popped flit, registered.
REQ-011 SHALL have port: rd_valid  output  1  rd_data valid, one-cycle pulse.
REQ-012 SHALL have ports: fifo_empty, fifo_full  output  1 each  FIFO status.
REQ-013 SHALL have port: overflow  output  1  sticky; a flit was dropped because the FIFO was full.
REQ-014 SHALL have ports: rx_count, err_count, null_count  output  8 each  saturating counters.
REQ-015 SHALL have port: err_pulse  output  1  one-cycle pulse per erroneous flit.
REQ-016 SHALL have port: src_seen  output  16  bit s set once a non-null flit arrives from src s.
REQ-017 SHALL have ports: all_seen, done  output  1 each  every other node seen; stream ended.

Function
REQ-018 SHALL accept a flit on every rising edge with in_valid=1; no backpressure.
REQ-019 SHALL treat datain==20'h00000 as a null flit: null_count+1, no storage, no check, no src_seen update.
REQ-020 SHALL, for a non-null flit, increment rx_count, set src_seen[datain[15:12]], and write the flit to the FIFO if not full.
REQ-021 SHALL flag a non-null flit erroneous if dest!=NODE_ID, payload!=dest, or src==NODE_ID; err_count+1 and err_pulse=1 on the next cycle; the flit is still stored.
REQ-022 SHALL saturate all 8-bit counters at 8'hFF; no wrap.
REQ-023 SHALL drop a write when the FIFO is full and rd_en=0, and set overflow until clear or reset.
REQ-024 SHALL accept a write when full and rd_en=1 in the same cycle; occupancy unchanged, no overflow.
REQ-025 SHALL ignore rd_en when empty; same-cycle write to an empty FIFO is stored and not bypassed.
REQ-026 SHALL present the popped entry on rd_data with rd_valid=1 one cycle after rd_en; rd_data holds its last value otherwise.
REQ-027 SHALL drive all_seen = ((src_seen | (1<<NODE_ID)) == 16'hFFFF), combinationally.
REQ-028 SHALL implement FSM IDLE -> ACTIVE on the first non-null flit; in ACTIVE an 8-bit idle counter resets on any in_valid and increments otherwise.
REQ-029 SHALL transition ACTIVE -> DONE when the idle counter reaches TIMEOUT; done=1 in DONE only.
REQ-030 SHALL keep accepting and counting flits in DONE; the FSM stays in DONE until clear or reset.
REQ-031 SHALL, on clear=1, zero counters, src_seen, overflow and FIFO pointers, drop a same-cycle flit and rd_en, and return the FSM to IDLE.

Reset
REQ-032 SHALL, on rst low, asynchronously set: FSM IDLE, FIFO empty, rd_data=20'h00000, rd_valid=0, overflow=0, counters=0, err_pulse=0, src_seen=0, done=0.
REQ-033 SHALL abandon any in-progress stream on reset mid-operation; no state is retained.

Verification
REQ-034 SHALL check, with NODE_ID=1, flits 20'h0F011 and 20'h0E011 -> rx_count=2, err_count=0, src_seen=16'hC000, two FIFO pops return the flits in order.
REQ-035 SHALL check 20'h02022 at NODE_ID=1 -> err_pulse one cycle later, err_count=1, flit stored.
REQ-036 SHALL check 17 back-to-back non-null flits with no reads, FIFO_DEPTH=16 -> fifo_full, 17th dropped, overflow=1, rx_count=17.
REQ-037 SHALL check 15 null flits, then one good flit, then TIMEOUT=64 idle cycles -> null_count=15, done rises exactly 64 cycles after the last in_valid.
REQ-038 SHALL check one good flit from each src 0,2..15 at NODE_ID=1 -> all_seen=1; then clear -> all outputs at reset values, FSM IDLE.
REQ-039 SHALL check rst asserted mid-stream with the FIFO half full -> all outputs at reset values immediately, without waiting for a clock edge.
